// File: rtl/mano_pkg.sv
// Shared defaults and loader state enumeration for the Mano program loader.
package mano_pkg;
    localparam int DEPTH_DEF = 9;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } loader_state_t;
endpackage

// File: rtl/mano_program_loader_if.sv
// Load stream, CPU read port and status bundle of the Mano program loader.
interface mano_program_loader_if #(
    parameter int WIDTH = mano_pkg::WIDTH_DEF
);
    logic             ld_start;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_ready;
    logic [WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             cpu_run;
    logic             ld_done;
    logic             ld_err;
    logic [3:0]       word_cnt;

    modport master (
        output ld_start, ld_valid, ld_data, rd_addr,
        input  ld_ready, rd_data, cpu_run, ld_done, ld_err, word_cnt
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, rd_addr,
        output ld_ready, rd_data, cpu_run, ld_done, ld_err, word_cnt
    );
endinterface

// File: rtl/mano_prog_mem.sv
// Program memory: synchronous write, asynchronous read (zero when out of range),
// contents cleared by the asynchronous reset.
module mano_prog_mem
    import mano_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             SysClk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [CNT_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge SysClk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == CNT_W'(i)) mem[i] <= wdata;
            end
        end
    end

    // Decoded read keeps addresses at or above DEPTH reading as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == WIDTH'(i)) rdata = mem[i];
        end
    end
endmodule

// File: rtl/mano_program_loader.sv
// Streams a program image into memory and then releases the CPU.
// Optional checksum byte after the image: define LOADER_CHECKSUM_EN.
module mano_program_loader
    import mano_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  SysClk,
    input  logic                  rst_n,
    mano_program_loader_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] ptr;
    logic             ready_q;
    logic             run_q;
    logic             xfer;
    logic             wr_en;

    // ld_start wins over a coincident byte, so that byte never counts as a transfer.
    assign xfer  = bus.ld_valid & ready_q & ~bus.ld_start;
    assign wr_en = xfer & (state == ST_LOAD);

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] csum;
    logic [WIDTH-1:0] csum_next;
    logic             err_q;

    assign csum_next  = csum + bus.ld_data;
    assign bus.ld_err = err_q;
`else
    assign bus.ld_err = 1'b0;
`endif

    always_ff @(posedge SysClk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
            err_q   <= 1'b0;
`endif
        end else if (bus.ld_start) begin
            state   <= ST_LOAD;
            ptr     <= '0;
            ready_q <= 1'b1;
            run_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum_next;
                        if (ptr == LAST) state <= ST_CHECK;
`else
                        if (ptr == LAST) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b0;
                            run_q   <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) begin
                        ready_q <= 1'b0;
                        if (csum_next == '0) begin
                            state <= ST_RUN;
                            run_q <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ERROR: state <= ST_ERROR;
`endif
                ST_RUN:  state <= ST_RUN;
                ST_IDLE: state <= ST_IDLE;
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_ready = ready_q;
    assign bus.cpu_run  = run_q;
    assign bus.ld_done  = run_q;
    assign bus.word_cnt = ptr;

    mano_prog_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .SysClk (SysClk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .waddr  (ptr),
        .wdata  (bus.ld_data),
        .raddr  (bus.rd_addr),
        .rdata  (bus.rd_data)
    );
endmodule

// File: tb/tb_mano_program_loader.sv
// Self-checking bench for mano_program_loader: vector table, directed corner sequences, randomized run.
module tb_mano_program_loader;
    import mano_pkg::*;

    localparam int DEPTH = 9;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_SUM   = 2;
    localparam int P_GO    = 3;
    localparam int P_BAD   = 4;

    logic SysClk = 1'b0;
    logic rst_n  = 1'b0;

    mano_program_loader_if #(.WIDTH(8)) bus();

    mano_program_loader #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .SysClk (SysClk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 SysClk = ~SysClk;

    int checks   = 0;
    int failures = 0;

    int         m_phase;
    int         m_ptr;
    int         m_sum;
    logic [7:0] m_mem [DEPTH];

    typedef struct {
        bit         st;
        bit         v;
        logic [7:0] d;
        logic [7:0] a;
        bit         e_ready;
        bit         e_run;
        logic [3:0] e_cnt;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit v, logic [7:0] d, logic [7:0] a,
                                bit er, bit eu, logic [3:0] ec, logic [7:0] ed);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.a = a;
        r.e_ready = er; r.e_run = eu; r.e_cnt = ec; r.e_rd = ed;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_phase = P_IDLE;
        m_ptr   = 0;
        m_sum   = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    endfunction

    // Behavioural view: a load fills the image in order, then optionally verifies one sum byte.
    function automatic void m_step(bit st, bit v, logic [7:0] d);
        bit accepting;
        accepting = (m_phase == P_FILL) || (m_phase == P_SUM);
        if (st) begin
            m_phase = P_FILL;
            m_ptr   = 0;
            m_sum   = 0;
        end else if (v && accepting) begin
            if (m_phase == P_FILL) begin
                m_mem[m_ptr] = d;
                m_ptr++;
                m_sum = (m_sum + int'(d)) % 256;
                if (m_ptr == DEPTH) m_phase = CK ? P_SUM : P_GO;
            end else begin
                m_phase = ((m_sum + int'(d)) % 256 == 0) ? P_GO : P_BAD;
            end
        end
    endfunction

    function automatic logic [7:0] m_read(logic [7:0] a);
        return (int'(a) < DEPTH) ? m_mem[int'(a)] : 8'h00;
    endfunction

    task automatic drive(bit st, bit v, logic [7:0] d, logic [7:0] a);
        bus.ld_start = st;
        bus.ld_valid = v;
        bus.ld_data  = d;
        bus.rd_addr  = a;
        @(posedge SysClk);
        m_step(st, v, d);
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_ready"}, bus.ld_ready, (m_phase == P_FILL) || (m_phase == P_SUM));
        chk({tag, "_run"},   bus.cpu_run,  m_phase == P_GO);
        chk({tag, "_done"},  bus.ld_done,  m_phase == P_GO);
        chk({tag, "_err"},   bus.ld_err,   m_phase == P_BAD);
        chk({tag, "_cnt"},   bus.word_cnt, m_ptr);
        chk({tag, "_rd"},    bus.rd_data,  m_read(bus.rd_addr));
    endtask

    task automatic read_at(logic [7:0] a, logic [7:0] exp, string name);
        bus.rd_addr = a;
        #1;
        chk(name, bus.rd_data, exp);
    endtask

    task automatic do_reset();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge SysClk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        bus.rd_addr  = 8'h00;
        m_reset();

        #12;
        chk("rst_ready", bus.ld_ready, 0);
        chk("rst_run",   bus.cpu_run,  0);
        chk("rst_done",  bus.ld_done,  0);
        chk("rst_err",   bus.ld_err,   0);
        chk("rst_cnt",   bus.word_cnt, 0);
        chk("rst_rd",    bus.rd_data,  0);
        @(posedge SysClk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'h3C, 8'h00);
        chk("idle_ignores_valid_cnt", bus.word_cnt, 0);
        chk("idle_ready", bus.ld_ready, 0);

        // Basic load 0x01..0x09, sum byte 0xD3 (ignored when no checksum stage), out-of-range reads.
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(1'b0, 1'b1, 8'(k), 8'(k - 1), (k < 9) || CK, (k == 9) && !CK,
                             4'(k), 8'(k)));
        tbl.push_back(mk(1'b0, 1'b1, 8'hD3, 8'h04, 1'b0, 1'b1, 4'd9, 8'h05));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b1, 4'd9, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 4'd9, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1, 4'd9, 8'h09));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].a);
            chk($sformatf("tbl%0d_ready", i), bus.ld_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_run",   i), bus.cpu_run,  tbl[i].e_run);
            chk($sformatf("tbl%0d_done",  i), bus.ld_done,  tbl[i].e_run);
            chk($sformatf("tbl%0d_err",   i), bus.ld_err,   0);
            chk($sformatf("tbl%0d_cnt",   i), bus.word_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_rd",    i), bus.rd_data,  tbl[i].e_rd);
        end

        // Reload from RUN, then restart colliding with a byte.
        drive(1'b1, 1'b0, 8'h00, 8'h04);
        chk("reload_run",   bus.cpu_run,  0);
        chk("reload_done",  bus.ld_done,  0);
        chk("reload_ready", bus.ld_ready, 1);
        chk("reload_cnt",   bus.word_cnt, 0);
        chk("reload_keep",  bus.rd_data,  8'h05);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 8'(i));
            chk($sformatf("part%0d_cnt", i), bus.word_cnt, i + 1);
        end
        drive(1'b1, 1'b1, 8'h77, 8'h04);
        chk("collide_cnt", bus.word_cnt, 0);
        chk("collide_mem4", bus.rd_data, 8'h05);
        read_at(8'h00, 8'h10, "collide_mem0");
        drive(1'b0, 1'b1, 8'h55, 8'h00);
        chk("after_collide_cnt", bus.word_cnt, 1);
        chk("after_collide_mem0", bus.rd_data, 8'h55);
        chk_model("collide");

        // Reset in the middle of a load.
        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 8'(8'h60 + i), 8'(i));
        chk("pre_rst_cnt", bus.word_cnt, 5);
        #2;
        rst_n = 1'b0;
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b1;
        m_reset();
        #1;
        chk("mid_rst_ready", bus.ld_ready, 0);
        chk("mid_rst_run",   bus.cpu_run,  0);
        chk("mid_rst_done",  bus.ld_done,  0);
        chk("mid_rst_err",   bus.ld_err,   0);
        chk("mid_rst_cnt",   bus.word_cnt, 0);
        for (int a = 0; a <= 10; a++) read_at(8'(a), 8'h00, $sformatf("mid_rst_rd%0d", a));
        read_at(8'hFF, 8'h00, "mid_rst_rdFF");
        repeat (2) @(posedge SysClk);
        #1;
        chk("held_rst_ready", bus.ld_ready, 0);
        chk("held_rst_cnt",   bus.word_cnt, 0);
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge SysClk); #1;
        chk("post_rst_idle_ready", bus.ld_ready, 0);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 8'hA5, 8'h00);
        chk("post_rst_cnt", bus.word_cnt, 1);
        chk("post_rst_mem0", bus.rd_data, 8'hA5);

        // Gap in ld_valid with the byte held: only two writes.
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 8'h11, 8'h00);
        drive(1'b0, 1'b0, 8'hAA, 8'h01);
        chk("gap_cnt", bus.word_cnt, 1);
        chk("gap_mem1", bus.rd_data, 8'h00);
        drive(1'b0, 1'b1, 8'hAA, 8'h01);
        chk("gap2_cnt", bus.word_cnt, 2);
        chk("gap2_mem1", bus.rd_data, 8'hAA);
        read_at(8'h02, 8'h00, "gap2_mem2");

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        for (int k = 1; k <= 9; k++) drive(1'b0, 1'b1, 8'(k), 8'h00);
        chk("ck_wait_ready", bus.ld_ready, 1);
        chk("ck_wait_run",   bus.cpu_run,  0);
        drive(1'b0, 1'b1, 8'hD4, 8'h00);
        chk("ck_bad_err",   bus.ld_err,   1);
        chk("ck_bad_run",   bus.cpu_run,  0);
        chk("ck_bad_ready", bus.ld_ready, 0);
        drive(1'b0, 1'b1, 8'h2C, 8'h00);
        chk("ck_bad_sticky", bus.ld_err, 1);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        chk("ck_clear_err",   bus.ld_err,   0);
        chk("ck_clear_ready", bus.ld_ready, 1);
`endif

        // Randomized traffic against the behavioural model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit         st;
            bit         v;
            logic [7:0] d;
            logic [7:0] a;
            st = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
            drive(st, v, d, a);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
